// File: rtl/cc3000_apb_spi_slave.sv
// APB3 completer bridging Cortex-M3 register accesses to an 8-bit mode-1 SPI master for the CC3000.
// Define CC3000_IRQ_EN to synchronise CC_IRQ_N into a W1C pending flag that drives FABINT.
module cc3000_apb_spi_slave #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DIV_RESET  = 8'd4
) (
  input  logic        FAB_CLK,
  input  logic        M2F_RESET_N,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        SPI_SCLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        SPI_CS_N,
  input  logic        CC_IRQ_N,
  output logic        FABINT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_next;

  logic          ctrl_cs;
  logic [7:0]    clkdiv;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_empty, tx_full, rx_empty, rx_full, busy, irq_pend, irq_raw;
  logic          access, setup_rd, bad_addr, err, ctrl_wr;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [1:0]    reg_sel;
  logic [31:0]   rd_data, prdata_q;
  logic          sclk_q, mosi_q, cs_n_q;
  logic          sclk_rise, sclk_fall, edge_tick, start_ok;
  logic [7:0]    div_cnt, tx_sh, rx_sh;
  logic [2:0]    bit_cnt;
  logic          unused_bits;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign busy     = (state != IDLE);
  assign start_ok = ctrl_cs & ~tx_empty & ~rx_full;
  assign edge_tick = (div_cnt >= clkdiv);

  assign access   = PSEL & PENABLE;
  assign setup_rd = PSEL & ~PENABLE & ~PWRITE;
  assign bad_addr = |PADDR[7:4];
  assign reg_sel  = PADDR[3:2];

  // Erroring accesses leave all state untouched; the flag only shows in the access phase.
  always_comb begin
    err = 1'b0;
    if (bad_addr) err = 1'b1;
    else begin
      case (reg_sel)
        2'd2:    err = PWRITE ? tx_full : 1'b1;
        2'd3:    err = PWRITE ? 1'b1 : rx_empty;
        default: err = 1'b0;
      endcase
    end
  end

  assign PSLVERR = access & err;
  assign PREADY  = 1'b1;
  assign tx_push = access & PWRITE & (reg_sel == 2'd2) & ~err;
  assign rx_pop  = access & ~PWRITE & (reg_sel == 2'd3) & ~err;
  assign ctrl_wr = access & PWRITE & (reg_sel == 2'd0) & ~bad_addr;

  always_comb begin
    rd_data = '0;
    if (!bad_addr) begin
      case (reg_sel)
        2'd0: rd_data = {16'd0, clkdiv, 7'd0, ctrl_cs};
        2'd1: rd_data = {25'd0, irq_raw, irq_pend, busy, rx_full, rx_empty, tx_full, tx_empty};
        2'd3: if (!rx_empty) rd_data = {24'd0, rx_mem[rx_rd]};
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      prdata_q <= '0;
      ctrl_cs  <= 1'b0;
      clkdiv   <= DIV_RESET;
    end else begin
      if (setup_rd) prdata_q <= rd_data;
      if (ctrl_wr) begin
        ctrl_cs <= PWDATA[0];
        clkdiv  <= PWDATA[15:8];
      end
    end
  end

  assign PRDATA = prdata_q;

  always_ff @(posedge FAB_CLK) begin
    if (tx_push) tx_mem[tx_wr] <= PWDATA[7:0];
    if (rx_push) rx_mem[rx_wr] <= {rx_sh[6:0], SPI_MISO};
  end

  // Simultaneous push and pop cancel in the count; pointers still both advance.
  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      tx_wr <= '0; tx_rd <= '0; tx_cnt <= '0;
      rx_wr <= '0; rx_rd <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      if (tx_push && !tx_pop) tx_cnt <= tx_cnt + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CW'(1);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      if (rx_push && !rx_pop) rx_cnt <= rx_cnt + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CW'(1);
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) state <= IDLE;
    else              state <= state_next;
  end

  // The first rising SCLK edge leaves LOAD; later edges fire once per CLKDIV+1 cycles.
  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    sclk_rise  = 1'b0;
    sclk_fall  = 1'b0;
    case (state)
      IDLE:  if (start_ok) begin state_next = LOAD; tx_pop = 1'b1; end
      LOAD:  begin state_next = SHIFT; sclk_rise = 1'b1; end
      SHIFT: if (edge_tick) begin
               if (sclk_q) begin
                 sclk_fall = 1'b1;
                 if (bit_cnt == 3'd7) begin state_next = DONE; rx_push = 1'b1; end
               end else sclk_rise = 1'b1;
             end
      DONE:  if (start_ok) begin state_next = LOAD; tx_pop = 1'b1; end
             else state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      sclk_q <= 1'b0; mosi_q <= 1'b0; cs_n_q <= 1'b1;
      div_cnt <= '0; bit_cnt <= '0; tx_sh <= '0; rx_sh <= '0;
    end else begin
      if (tx_pop) tx_sh <= tx_mem[tx_rd];
      if (sclk_rise) begin
        sclk_q <= 1'b1;
        mosi_q <= tx_sh[7];
        tx_sh  <= {tx_sh[6:0], 1'b0};
      end
      if (sclk_fall) begin
        sclk_q  <= 1'b0;
        rx_sh   <= {rx_sh[6:0], SPI_MISO};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == LOAD) bit_cnt <= '0;
      if (state == SHIFT && !edge_tick) div_cnt <= div_cnt + 8'd1;
      else                              div_cnt <= '0;
      cs_n_q <= (state_next == IDLE) ? ~ctrl_cs : 1'b0;
    end
  end

  assign SPI_SCLK = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS_N = cs_n_q;

`ifdef CC3000_IRQ_EN
  logic [2:0] irq_sync;
  logic       stat_w1c;

  assign stat_w1c = access & PWRITE & ~bad_addr & (reg_sel == 2'd1) & PWDATA[5];

  // A falling edge arriving with the clear write keeps the flag set.
  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      irq_sync <= 3'b111;
      irq_pend <= 1'b0;
    end else begin
      irq_sync <= {irq_sync[1:0], CC_IRQ_N};
      irq_pend <= (irq_sync[2] & ~irq_sync[1]) | (irq_pend & ~stat_w1c);
    end
  end

  assign irq_raw = ~irq_sync[1];
`else
  assign irq_pend = 1'b0;
  assign irq_raw  = 1'b0;
`endif

  assign FABINT = irq_pend;
  assign unused_bits = ^{PWDATA[31:16], PADDR[1:0], CC_IRQ_N};

endmodule

// File: tb/tb_cc3000_apb_spi_slave.sv
// Testbench for cc3000_apb_spi_slave: directed register/SPI scenarios followed by randomized transfers
// checked against a queue-based model of the FIFOs and an SPI slave that logs MOSI and serves MISO.
module tb_cc3000_apb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n, psel, penable, pwrite, irq_n;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, sclk, mosi, cs_n, fabint;
  logic        miso = 1'b0;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  cc3000_apb_spi_slave #(.FIFO_DEPTH(4), .DIV_RESET(8'd4)) dut (
    .FAB_CLK(clk), .M2F_RESET_N(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_MISO(miso), .SPI_CS_N(cs_n),
    .CC_IRQ_N(irq_n), .FABINT(fabint)
  );

  // SPI slave: serves planned MISO bits on each rising edge, logs MOSI and SCLK high time on each fall.
  logic miso_plan [2048];
  logic mosi_log  [2048];
  int   n_rise = 0;
  int   n_fall = 0;
  int   high_bad = 0;
  time  t_rise = 0;
  time  exp_high = 10;

  always @(posedge sclk) begin
    miso = (n_rise < 2048) ? miso_plan[n_rise] : 1'b0;
    t_rise = $time;
    n_rise++;
  end

  always @(negedge sclk) begin
    if (($time - t_rise) != exp_high) high_bad++;
    if (n_fall < 2048) mosi_log[n_fall] = mosi;
    n_fall++;
  end

  logic [31:0] rd;
  logic        e, ok;
  logic [7:0]  b, r;
  logic [7:0]  model_tx[$];
  logic [7:0]  model_rx[$];
  int          base, hb, plan_idx, n, div;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                output logic [31:0] rdata, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rdata = prdata;
    err   = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic plan_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) miso_plan[plan_idx + i] = v[7 - i];
    plan_idx += 8;
  endtask

  function automatic logic [7:0] mosi_byte(input int start);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7 - i] = mosi_log[start + i];
    return v;
  endfunction

  task automatic wait_idle(input string tag, input logic need_empty);
    logic [31:0] st;
    logic        er, done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      apply_stimulus(1'b0, 8'h04, 32'd0, st, er);
      if (!st[4] && (st[0] || !need_empty)) begin done = 1'b1; break; end
    end
    check_output(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_rises(input int target, output logic reached);
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_rise >= target) begin reached = 1'b1; break; end
    end
  endtask

  initial begin
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_n = 1'b1;

    // Reset values and register map defaults
    apply_reset();
    #1;
    check_output("rst_prdata", prdata, 32'd0);
    check_output("rst_pready", {31'd0, pready}, 32'd1);
    check_output("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check_output("rst_sclk", {31'd0, sclk}, 32'd0);
    check_output("rst_mosi", {31'd0, mosi}, 32'd0);
    check_output("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check_output("rst_fabint", {31'd0, fabint}, 32'd0);
    apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
    check_output("rst_stat", rd, 32'h05);
    check_output("rst_stat_err", {31'd0, e}, 32'd0);
    apply_stimulus(1'b0, 8'h00, 32'd0, rd, e);
    check_output("rst_ctrl", rd, 32'h0000_0400);

    // Single byte at CLKDIV=0: 0xA5 out, 0x3C in
    exp_high = 10;
    base = n_rise; hb = high_bad; plan_idx = n_rise;
    plan_byte(8'h3C);
    apply_stimulus(1'b1, 8'h00, 32'h001, rd, e);
    apply_stimulus(1'b1, 8'h08, 32'hA5, rd, e);
    check_output("b1_push_err", {31'd0, e}, 32'd0);
    check_output("b1_cs_n", {31'd0, cs_n}, 32'd0);
    wait_idle("b1_idle", 1'b1);
    check_output("b1_rises", n_rise - base, 32'd8);
    check_output("b1_mosi", {24'd0, mosi_byte(base)}, 32'hA5);
    check_output("b1_sclk_high", high_bad - hb, 32'd0);
    apply_stimulus(1'b0, 8'h0C, 32'd0, rd, e);
    check_output("b1_rxdata", rd, 32'h3C);
    check_output("b1_rx_err", {31'd0, e}, 32'd0);
    apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
    check_output("b1_stat_after", rd, 32'h05);

    // FIFO full and the error cases with CS off
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 8'h08, 32'h10 + i, rd, e);
      check_output($sformatf("full_push%0d_err", i), {31'd0, e}, (i == 4) ? 32'd1 : 32'd0);
    end
    apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
    check_output("full_stat", rd, 32'h06);
    apply_stimulus(1'b0, 8'h0C, 32'd0, rd, e);
    check_output("empty_pop_err", {31'd0, e}, 32'd1);
    check_output("empty_pop_data", rd, 32'd0);
    apply_stimulus(1'b0, 8'h08, 32'd0, rd, e);
    check_output("rd_txdata_err", {31'd0, e}, 32'd1);
    check_output("rd_txdata_data", rd, 32'd0);
    apply_stimulus(1'b1, 8'h0C, 32'h55, rd, e);
    check_output("wr_rxdata_err", {31'd0, e}, 32'd1);
    apply_stimulus(1'b1, 8'h40, 32'h0000_FF01, rd, e);
    check_output("bad_addr_err", {31'd0, e}, 32'd1);
    apply_stimulus(1'b0, 8'h00, 32'd0, rd, e);
    check_output("bad_addr_no_write", rd, 32'h0000_0400);

    // Clearing CS during byte 1 finishes that byte only
    apply_reset();
    exp_high = 40;
    apply_stimulus(1'b1, 8'h08, 32'h81, rd, e);
    apply_stimulus(1'b1, 8'h08, 32'h7E, rd, e);
    base = n_rise; hb = high_bad; plan_idx = n_rise;
    plan_byte(8'h5A);
    plan_byte(8'h00);
    apply_stimulus(1'b1, 8'h00, 32'h301, rd, e);
    wait_rises(base + 1, ok);
    check_output("csclr_started", {31'd0, ok}, 32'd1);
    apply_stimulus(1'b1, 8'h00, 32'h300, rd, e);
    wait_idle("csclr_idle", 1'b0);
    check_output("csclr_rises", n_rise - base, 32'd8);
    check_output("csclr_mosi", {24'd0, mosi_byte(base)}, 32'h81);
    check_output("csclr_sclk_high", high_bad - hb, 32'd0);
    check_output("csclr_cs_n", {31'd0, cs_n}, 32'd1);
    apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
    check_output("csclr_stat", rd, 32'h00);
    apply_stimulus(1'b0, 8'h0C, 32'd0, rd, e);
    check_output("csclr_rxdata", rd, 32'h5A);

    // Reset during the 4th bit aborts the byte
    apply_reset();
    exp_high = 20;
    base = n_rise; plan_idx = n_rise;
    plan_byte(8'hFF);
    apply_stimulus(1'b1, 8'h08, 32'hC3, rd, e);
    apply_stimulus(1'b1, 8'h00, 32'h101, rd, e);
    wait_rises(base + 4, ok);
    check_output("abort_reached_bit4", {31'd0, ok}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("abort_sclk", {31'd0, sclk}, 32'd0);
    check_output("abort_mosi", {31'd0, mosi}, 32'd0);
    check_output("abort_cs_n", {31'd0, cs_n}, 32'd1);
    check_output("abort_prdata", prdata, 32'd0);
    check_output("abort_fabint", {31'd0, fabint}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
    check_output("abort_stat", rd, 32'h05);

    // Interrupt path
    @(negedge clk);
    irq_n = 1'b0;
`ifdef CC3000_IRQ_EN
    repeat (3) @(posedge clk);
    #1;
    check_output("irq_fabint_set", {31'd0, fabint}, 32'd1);
    apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
    check_output("irq_stat_set", rd, 32'h65);
    apply_stimulus(1'b1, 8'h04, 32'h20, rd, e);
    check_output("irq_fabint_clr", {31'd0, fabint}, 32'd0);
    apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
    check_output("irq_stat_clr", rd, 32'h45);
`else
    repeat (6) @(posedge clk);
    #1;
    check_output("noirq_fabint", {31'd0, fabint}, 32'd0);
    apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
    check_output("noirq_stat", rd, 32'h05);
`endif
    @(negedge clk);
    irq_n = 1'b1;

    // Randomized bursts: the model tracks TX acceptance and expected RX bytes
    apply_reset();
    for (int it = 0; it < 6; it++) begin
      model_tx.delete();
      model_rx.delete();
      div = $urandom_range(0, 2);
      exp_high = (div + 1) * 10;
      apply_stimulus(1'b1, 8'h00, div << 8, rd, e);
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        apply_stimulus(1'b1, 8'h08, {24'd0, b}, rd, e);
        check_output($sformatf("rnd%0d_push%0d_err", it, k), {31'd0, e},
                     (model_tx.size() == 4) ? 32'd1 : 32'd0);
        if (model_tx.size() < 4) model_tx.push_back(b);
      end
      base = n_rise; hb = high_bad; plan_idx = n_rise;
      foreach (model_tx[k]) begin
        r = 8'($urandom);
        model_rx.push_back(r);
        plan_byte(r);
      end
      apply_stimulus(1'b1, 8'h00, (div << 8) | 1, rd, e);
      wait_idle($sformatf("rnd%0d_idle", it), 1'b1);
      apply_stimulus(1'b1, 8'h00, div << 8, rd, e);
      check_output($sformatf("rnd%0d_rises", it), n_rise - base, 8 * model_tx.size());
      check_output($sformatf("rnd%0d_sclk_high", it), high_bad - hb, 32'd0);
      foreach (model_tx[k])
        check_output($sformatf("rnd%0d_mosi%0d", it, k), {24'd0, mosi_byte(base + 8 * k)},
                     {24'd0, model_tx[k]});
      foreach (model_rx[k]) begin
        apply_stimulus(1'b0, 8'h0C, 32'd0, rd, e);
        check_output($sformatf("rnd%0d_rx%0d", it, k), rd, {24'd0, model_rx[k]});
      end
      apply_stimulus(1'b0, 8'h04, 32'd0, rd, e);
      check_output($sformatf("rnd%0d_stat", it), rd, 32'h05);
      check_output($sformatf("rnd%0d_cs_n", it), {31'd0, cs_n}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
